// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundle of the two cache-controller ports and the memory port
// seen by mem_arbiter.
//   master : cache controllers + memory (drive req/rd/wr/addr/wdata, mem_rdata)
//   slave  : arbiter (drives gnt, rdata/rvalid, mem command, err)
interface mem_arbiter_if;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;

  logic          req0, req1;
  logic          rd0, rd1, wr0, wr1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1;
  logic [DW-1:0] rdata0, rdata1;
  logic          rvalid0, rvalid1;
  logic          mem_rd, mem_wr;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          err;

  modport master (
    output req0, req1, rd0, rd1, wr0, wr1, addr0, addr1, wdata0, wdata1,
    output mem_rdata,
    input  gnt0, gnt1, rdata0, rdata1, rvalid0, rvalid1,
    input  mem_rd, mem_wr, mem_addr, mem_wdata, err
  );

  modport slave (
    input  req0, req1, rd0, rd1, wr0, wr1, addr0, addr1, wdata0, wdata1,
    input  mem_rdata,
    output gnt0, gnt1, rdata0, rdata1, rvalid0, rvalid1,
    output mem_rd, mem_wr, mem_addr, mem_wdata, err
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: grants whole cache transactions on the shared four-bank memory
// to either the I-cache (port 0) or D-cache (port 1) controller, muxes the
// owner's command onto the memory port, and steers fixed-latency read returns
// back to the issuing port.
// Ports:
//   i_clk    system clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   bus      mem_arbiter_if.slave (requests, grants, memory command, returns, err)
// Parameters: RD_LAT (memory read latency, 1..4), MAX_HOLD (ownership limit, 2..255)
// Build option: ARB_FIXED_PRIO_EN gives port 1 every tie; otherwise round-robin.
module mem_arbiter #(
  parameter int unsigned RD_LAT   = 2,
  parameter int unsigned MAX_HOLD = 16
) (
  input logic           i_clk,
  input logic           i_rst_n,
  mem_arbiter_if.slave  bus
);

  localparam int unsigned HW = 8;
  localparam int unsigned DW = 16;

  typedef enum logic [1:0] {IDLE, OWN0, OWN1, DRAIN} state_t;

  state_t              r_state, w_next;
  logic [HW-1:0]       r_hold;
  logic [RD_LAT-1:0]   r_pipe_vld;
  logic [RD_LAT-1:0]   r_pipe_port;

  logic                w_own0, w_own1;
  logic                w_rd_sel, w_wr_sel;
  logic [DW-1:0]       w_addr_sel, w_wdata_sel;
  logic                w_conflict, w_fwd_rd, w_fwd_wr;
  logic                w_hold_exp, w_pending, w_tie_win1;
  logic                w_rvalid0, w_rvalid1;

`ifdef ARB_FIXED_PRIO_EN
  assign w_tie_win1 = 1'b1;
`else
  logic r_last_owner;
  // Tie goes to whichever port did not own last.
  assign w_tie_win1 = ~r_last_owner;
`endif

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  // Next state and owner command mux
  always_comb begin
    w_next      = r_state;
    w_own0      = (r_state == OWN0);
    w_own1      = (r_state == OWN1);
    w_rd_sel    = 1'b0;
    w_wr_sel    = 1'b0;
    w_addr_sel  = '0;
    w_wdata_sel = '0;

    if (w_own0) begin
      w_rd_sel    = bus.rd0;
      w_wr_sel    = bus.wr0;
      w_addr_sel  = bus.addr0;
      w_wdata_sel = bus.wdata0;
    end else if (w_own1) begin
      w_rd_sel    = bus.rd1;
      w_wr_sel    = bus.wr1;
      w_addr_sel  = bus.addr1;
      w_wdata_sel = bus.wdata1;
    end

    // rd&wr together is illegal: drop both and flag it
    w_conflict = w_rd_sel & w_wr_sel;
    w_fwd_rd   = w_rd_sel & ~w_wr_sel;
    w_fwd_wr   = w_wr_sel & ~w_rd_sel;
    w_hold_exp = (w_own0 | w_own1) && (r_hold == HW'(MAX_HOLD - 1));
    // A read forwarded in the leaving cycle still needs draining
    w_pending  = (|r_pipe_vld) | w_fwd_rd;

    case (r_state)
      IDLE: begin
        if (bus.req0 && bus.req1) w_next = w_tie_win1 ? OWN1 : OWN0;
        else if (bus.req0)        w_next = OWN0;
        else if (bus.req1)        w_next = OWN1;
      end
      OWN0: if (!bus.req0 || w_hold_exp) w_next = w_pending ? DRAIN : IDLE;
      OWN1: if (!bus.req1 || w_hold_exp) w_next = w_pending ? DRAIN : IDLE;
      DRAIN: if (!(|r_pipe_vld)) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Hold counter: zero outside ownership and on entry, counts owned cycles
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                                    r_hold <= '0;
    else if ((w_own0 || w_own1) && w_next == r_state) r_hold <= HW'(r_hold + HW'(1));
    else                                             r_hold <= '0;
  end

`ifndef ARB_FIXED_PRIO_EN
  // Remember the most recently granted port
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_last_owner <= 1'b1;
    else if (r_state == IDLE && w_next == OWN0) r_last_owner <= 1'b0;
    else if (r_state == IDLE && w_next == OWN1) r_last_owner <= 1'b1;
  end
`endif

  // Return pipeline of {valid, port}; reset discards in-flight reads
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pipe_vld  <= '0;
      r_pipe_port <= '0;
    end else begin
      r_pipe_vld[0]  <= w_fwd_rd;
      r_pipe_port[0] <= w_own1;
      for (int i = 1; i < int'(RD_LAT); i++) begin
        r_pipe_vld[i]  <= r_pipe_vld[i-1];
        r_pipe_port[i] <= r_pipe_port[i-1];
      end
    end
  end

  assign w_rvalid0 = r_pipe_vld[RD_LAT-1] & ~r_pipe_port[RD_LAT-1];
  assign w_rvalid1 = r_pipe_vld[RD_LAT-1] &  r_pipe_port[RD_LAT-1];

  assign bus.gnt0      = w_own0;
  assign bus.gnt1      = w_own1;
  assign bus.mem_rd    = w_fwd_rd;
  assign bus.mem_wr    = w_fwd_wr;
  assign bus.mem_addr  = (w_fwd_rd | w_fwd_wr) ? w_addr_sel : '0;
  assign bus.mem_wdata = w_fwd_wr ? w_wdata_sel : '0;
  assign bus.err       = w_conflict | w_hold_exp;
  assign bus.rvalid0   = w_rvalid0;
  assign bus.rvalid1   = w_rvalid1;
  assign bus.rdata0    = w_rvalid0 ? bus.mem_rdata : '0;
  assign bus.rdata1    = w_rvalid1 ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a 2-cycle-latency
// memory model (contents 0x1000 + 3*index after reset, index = addr[7:0]).
module tb_mem_arbiter;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

`ifdef ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  always #5 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter #(.RD_LAT(2), .MAX_HOLD(16)) u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  // Memory model: writes at the clock edge, read data returned 2 cycles later
  logic [15:0] mem [0:255];
  logic [1:0]  p_vld;
  logic [15:0] p_addr0, p_addr1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 256; k++) mem[k] <= 16'h1000 + 16'(3 * k);
      p_vld   <= '0;
      p_addr0 <= '0;
      p_addr1 <= '0;
    end else begin
      if (bus.mem_wr) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
      p_vld   <= {p_vld[0], bus.mem_rd};
      p_addr0 <= bus.mem_addr;
      p_addr1 <= p_addr0;
    end
  end

  assign bus.mem_rdata = p_vld[1] ? mem[p_addr1[7:0]] : 16'h0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req0 = 0; bus.req1 = 0; bus.rd0 = 0; bus.rd1 = 0; bus.wr0 = 0; bus.wr1 = 0;
    bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
  endtask

  task automatic reset_dut();
    clear_inputs();
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
  endtask

  logic [15:0] exp_rd [0:3];

  initial begin
    exp_rd[0] = 16'h1000; exp_rd[1] = 16'h1006; exp_rd[2] = 16'h100C; exp_rd[3] = 16'h1012;

    // Reset state
    reset_dut();
    check("rst_gnt0",    16'(bus.gnt0), 16'(0));
    check("rst_gnt1",    16'(bus.gnt1), 16'(0));
    check("rst_rvalid0", 16'(bus.rvalid0), 16'(0));
    check("rst_rvalid1", 16'(bus.rvalid1), 16'(0));
    check("rst_rdata0",  bus.rdata0, 16'h0);
    check("rst_rdata1",  bus.rdata1, 16'h0);
    check("rst_mem_rd",  16'(bus.mem_rd), 16'(0));
    check("rst_mem_wr",  16'(bus.mem_wr), 16'(0));
    check("rst_addr",    bus.mem_addr, 16'h0);
    check("rst_wdata",   bus.mem_wdata, 16'h0);
    check("rst_err",     16'(bus.err), 16'(0));

    // Lone read burst on port 1
    bus.req1 = 1;
    #1 check("t1_gnt1_before", 16'(bus.gnt1), 16'(0));
    step();
    check("t1_gnt1", 16'(bus.gnt1), 16'(1));
    check("t1_gnt0", 16'(bus.gnt0), 16'(0));
    for (int i = 0; i < 6; i++) begin
      bus.rd1   = (i < 4);
      bus.addr1 = 16'h0100 + 16'(2 * i);
      #1;
      check("t1_mem_rd",   16'(bus.mem_rd), 16'(i < 4));
      check("t1_mem_addr", bus.mem_addr, (i < 4) ? bus.addr1 : 16'h0);
      check("t1_rvalid1",  16'(bus.rvalid1), 16'(i >= 2));
      check("t1_rdata1",   bus.rdata1, (i >= 2) ? exp_rd[i-2] : 16'h0);
      check("t1_rvalid0",  16'(bus.rvalid0), 16'(0));
      step();
    end
    bus.rd1 = 0; bus.req1 = 0;
    step();
    check("t1_release", 16'(bus.gnt1), 16'(0));

    // Tie after reset
    reset_dut();
    bus.req0 = 1; bus.req1 = 1;
    step();
    check("t2_first_gnt0", 16'(bus.gnt0), 16'(!FIXED));
    check("t2_first_gnt1", 16'(bus.gnt1), 16'(FIXED));
    if (FIXED) bus.req1 = 0; else bus.req0 = 0;
    step();
    check("t2_dead_gnt0", 16'(bus.gnt0), 16'(0));
    check("t2_dead_gnt1", 16'(bus.gnt1), 16'(0));
    step();
    check("t2_second_gnt0", 16'(bus.gnt0), 16'(FIXED));
    check("t2_second_gnt1", 16'(bus.gnt1), 16'(!FIXED));
    clear_inputs();
    step();

    // Write-back then refill on port 1, req0 pending, drain
    bus.req1 = 1;
    step();
    for (int i = 0; i < 13; i++) begin
      bus.req0   = 1;
      bus.req1   = (i < 8);
      bus.wr1    = (i < 4);
      bus.rd1    = (i >= 4 && i < 8);
      bus.addr1  = 16'h0010 + 16'(i % 4);
      bus.wdata1 = 16'hA5A5;
      #1;
      check("t3_gnt1",    16'(bus.gnt1), 16'(i <= 8));
      check("t3_gnt0",    16'(bus.gnt0), 16'(i == 12));
      check("t3_mem_wr",  16'(bus.mem_wr), 16'(i < 4));
      check("t3_wdata",   bus.mem_wdata, (i < 4) ? 16'hA5A5 : 16'h0);
      check("t3_rvalid1", 16'(bus.rvalid1), 16'(i >= 6 && i <= 9));
      check("t3_rdata1",  bus.rdata1, (i >= 6 && i <= 9) ? 16'hA5A5 : 16'h0);
      if (i < 12) step();
    end

    // Owner drives rd and wr together
    bus.rd1 = 0; bus.wr1 = 0;
    bus.rd0 = 1; bus.wr0 = 1; bus.addr0 = 16'h0040;
    #1;
    check("t4_mem_rd", 16'(bus.mem_rd), 16'(0));
    check("t4_mem_wr", 16'(bus.mem_wr), 16'(0));
    check("t4_addr",   bus.mem_addr, 16'h0);
    check("t4_err",    16'(bus.err), 16'(1));
    step();
    bus.rd0 = 0; bus.wr0 = 0;
    #1;
    check("t4_err_clr", 16'(bus.err), 16'(0));
    check("t4_gnt0",    16'(bus.gnt0), 16'(1));
    bus.req0 = 0;
    step();
    check("t4_release", 16'(bus.gnt0), 16'(0));

    // Hold limit with req1 pending
    reset_dut();
    bus.req0 = 1;
    step();
    bus.req1 = 1;
    for (int j = 1; j <= 16; j++) begin
      #1;
      check("t5_err",  16'(bus.err), 16'(j == 16));
      check("t5_gnt0", 16'(bus.gnt0), 16'(1));
      step();
    end
    check("t5_dead_gnt0", 16'(bus.gnt0), 16'(0));
    check("t5_dead_gnt1", 16'(bus.gnt1), 16'(0));
    check("t5_dead_err",  16'(bus.err), 16'(0));
    step();
    check("t5_next_gnt1", 16'(bus.gnt1), 16'(1));
    check("t5_next_gnt0", 16'(bus.gnt0), 16'(0));
    clear_inputs();
    step();

    // Reset one cycle after a read issued in OWN0
    bus.req0 = 1;
    step();
    bus.rd0 = 1; bus.addr0 = 16'h0002;
    #1 check("t6_mem_rd", 16'(bus.mem_rd), 16'(1));
    step();
    bus.rd0 = 0; bus.req0 = 0;
    rst_n = 1'b0;
    #1;
    check("t6_rst_gnt0",    16'(bus.gnt0), 16'(0));
    check("t6_rst_mem_rd",  16'(bus.mem_rd), 16'(0));
    check("t6_rst_rvalid0", 16'(bus.rvalid0), 16'(0));
    check("t6_rst_err",     16'(bus.err), 16'(0));
    step();
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("t6_no_rvalid0", 16'(bus.rvalid0), 16'(0));
      check("t6_rdata0",     bus.rdata0, 16'h0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
